// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams, locked per packet.
// Latency: handshake in cycle T -> tx_trigger_out in T+1; next owner granted one cycle after release.
// Backpressure: only the owner sees ready, and only in ISSUE; pacing follows tx_busy_in.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [8*NUM_REQ-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]   req_last_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic                 abort_out,
    output logic [7:0]           tx_byte_out,
    output logic                 tx_trigger_out,
    input  logic                 tx_busy_in
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_TIMEOUT > 0) ? CNT_W'(HOLD_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   hold_cnt;
    logic               last_q;
    logic [NUM_REQ-1:0] grant_q;

    logic [7:0]         req_byte [NUM_REQ];
    logic [PTR_W-1:0]   winner;
    logic               any_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
        assign req_byte[i] = req_data_in[8*i +: 8];
    end

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // Scan from the farthest offset down so the offset nearest ptr wins.
    always_comb begin
        winner  = ptr;
        any_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_in[PTR_W'((int'(ptr) + k) % NUM_REQ)]) begin
                winner  = PTR_W'((int'(ptr) + k) % NUM_REQ);
                any_vld = 1'b1;
            end
        end
    end

    assign req_ready_out = (state == ISSUE) ? grant_q : '0;
    assign grant_out     = grant_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            hold_cnt       <= '0;
            last_q         <= 1'b0;
            grant_q        <= '0;
            abort_out      <= 1'b0;
            tx_byte_out    <= '0;
            tx_trigger_out <= 1'b0;
        end else begin
            tx_trigger_out <= 1'b0;
            abort_out      <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    // A frame left running across reset must drain before the next grant.
                    if (any_vld && !tx_busy_in) begin
                        owner   <= winner;
                        grant_q <= NUM_REQ'(1) << winner;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_valid_in[owner]) begin
                        tx_byte_out    <= req_byte[owner];
                        last_q         <= req_last_in[owner];
                        tx_trigger_out <= 1'b1;
                        hold_cnt       <= '0;
                        state          <= WAIT_START;
                    end else if (HOLD_TIMEOUT > 0) begin
                        if (hold_cnt == CNT_LAST) begin
                            abort_out <= 1'b1;
                            grant_q   <= '0;
                            ptr       <= next_idx(owner);
                            state     <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                WAIT_START: begin
                    if (tx_busy_in) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_in) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr     <= next_idx(owner);
                            state   <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a busy-pacing transmitter model and a packet-level scoreboard.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int HOLD  = 16;
    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic [N-1:0]   req_valid_in;
    logic [8*N-1:0] req_data_in;
    logic [N-1:0]   req_last_in;
    logic [N-1:0]   req_ready_out;
    logic [N-1:0]   grant_out;
    logic           abort_out;
    logic [7:0]     tx_byte_out;
    logic           tx_trigger_out;
    logic           tx_busy_in = 1'b0;

    always #5 clk_in = ~clk_in;

    uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HOLD)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_last_in(req_last_in),
        .req_ready_out(req_ready_out), .grant_out(grant_out), .abort_out(abort_out),
        .tx_byte_out(tx_byte_out), .tx_trigger_out(tx_trigger_out), .tx_busy_in(tx_busy_in)
    );

    // Transmitter stand-in: busy from the cycle after trigger for one frame; never reset by the DUT.
    int tx_cnt = 0;
    always @(posedge clk_in) begin
        if (tx_trigger_out && !tx_busy_in) begin
            tx_busy_in <= 1'b1;
            tx_cnt     <= FRAME - 1;
        end else if (tx_busy_in) begin
            if (tx_cnt == 0) tx_busy_in <= 1'b0;
            else tx_cnt <= tx_cnt - 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] q_dat   [N][$];
    bit         q_last  [N][$];
    logic [7:0] exp_dat [N][$];
    bit         exp_last[N][$];
    bit         hold_off[N];
    int         sent_own[$];
    logic [7:0] sent_byte[$];
    int         abort_cnt = 0;
    int         trig_cnt = 0;

    task automatic push_byte(input int r, input logic [7:0] b, input bit last);
        q_dat[r].push_back(b);   q_last[r].push_back(last);
        exp_dat[r].push_back(b); exp_last[r].push_back(last);
    endtask

    task automatic withdraw(input int r);
        q_dat[r].delete(); q_last[r].delete(); exp_dat[r].delete(); exp_last[r].delete();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            withdraw(i);
            hold_off[i] = 1'b0;
        end
        sent_own.delete(); sent_byte.delete();
        abort_cnt = 0; trig_cnt = 0;
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        int r = -1;
        int c = 0;
        for (int i = 0; i < N; i++) if (g[i]) begin r = i; c++; end
        return (c == 1) ? r : -1;
    endfunction

    function automatic int first_valid(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Requester drivers: present the head of each queue unless held off.
    initial begin
        req_valid_in = '0; req_data_in = '0; req_last_in = '0;
        forever begin
            @(posedge clk_in); #1;
            for (int i = 0; i < N; i++) begin
                if (q_dat[i].size() > 0 && !hold_off[i]) begin
                    req_valid_in[i]        = 1'b1;
                    req_data_in[8*i +: 8]  = q_dat[i][0];
                    req_last_in[i]         = q_last[i][0];
                end else begin
                    req_valid_in[i] = 1'b0;
                    req_last_in[i]  = 1'b0;
                end
            end
        end
    end

    // Reference model: RR pick relative to the last released owner, packet lock, per-requester byte order, trigger protocol.
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] prev_valid = '0;
    bit           prev_trig = 1'b0;
    bit           watching = 1'b0;
    logic [7:0]   hold_byte = '0;
    int           model_ptr = 0;
    int           open_own = -1;

    always @(negedge clk_in) begin : monitor
        int o;
        int ew;
        bit lf;
        if (!rst_n_in) begin
            model_ptr = 0; open_own = -1; watching = 1'b0;
            prev_grant = '0; prev_trig = 1'b0; prev_valid = req_valid_in;
        end else begin
            for (int i = 0; i < N; i++)
                if (req_valid_in[i] && req_ready_out[i]) begin
                    void'(q_dat[i].pop_front()); void'(q_last[i].pop_front());
                end
            o = idx_of(grant_out);
            if (grant_out != '0 && o < 0) begin
                failures++; $display("FAIL grant_onehot: got %b", grant_out);
            end
            if (prev_grant == '0 && grant_out != '0) begin
                ew = first_valid(prev_valid, model_ptr);
                checks++;
                if (o != ew || (open_own >= 0 && o != open_own)) begin
                    failures++;
                    $display("FAIL rr_pick: got owner %0d expected %0d (open %0d)", o, ew, open_own);
                end
            end
            if (prev_grant != '0 && grant_out != '0 && grant_out != prev_grant) begin
                failures++; $display("FAIL grant_switch: got %b after %b", grant_out, prev_grant);
            end
            if (prev_grant != '0 && grant_out == '0) model_ptr = (idx_of(prev_grant) + 1) % N;
            if (abort_out) begin abort_cnt++; open_own = -1; end
            if (tx_trigger_out) begin
                trig_cnt++;
                checks++;
                if (tx_busy_in || prev_trig) begin
                    failures++; $display("FAIL trig_protocol: busy %0b prev_trig %0b expected 0 0", tx_busy_in, prev_trig);
                end
                if (o < 0 || exp_dat[o].size() == 0 || (open_own >= 0 && o != open_own)) begin
                    failures++; $display("FAIL trig_owner: owner %0d open %0d", o, open_own);
                end else begin
                    checks++;
                    if (tx_byte_out !== exp_dat[o][0]) begin
                        failures++; $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_byte_out, exp_dat[o][0]);
                    end
                    void'(exp_dat[o].pop_front());
                    lf = exp_last[o].pop_front();
                    open_own = lf ? -1 : o;
                end
                sent_own.push_back(o); sent_byte.push_back(tx_byte_out);
                watching = 1'b1; hold_byte = tx_byte_out;
            end else if (watching) begin
                if (tx_busy_in) watching = 1'b0;
                else if (tx_byte_out !== hold_byte) begin
                    failures++; $display("FAIL byte_stable: got 0x%0h expected 0x%0h", tx_byte_out, hold_byte);
                end
            end
            prev_grant = grant_out; prev_trig = tx_trigger_out; prev_valid = req_valid_in;
        end
    end

    task automatic do_reset();
        @(posedge clk_in); #1 rst_n_in = 1'b0;
        clear_all();
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string name);
        int n = 0;
        while (grant_out !== g && n < 3000) begin @(negedge clk_in); n++; end
        check(name, grant_out, g);
    endtask

    task automatic wait_any_grant(input string name);
        int n = 0;
        while (grant_out == '0 && n < 3000) begin @(negedge clk_in); n++; end
        check(name, 32'(grant_out != '0), 1);
    endtask

    task automatic wait_trig(input int cnt, input string name);
        int n = 0;
        while (trig_cnt < cnt && n < 3000) begin @(negedge clk_in); n++; end
        check(name, trig_cnt, cnt);
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (q_dat[i].size() != 0) return 1'b0;
        return grant_out == '0 && !tx_busy_in;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin @(negedge clk_in); n++; end while (!all_done() && n < budget);
        check(name, 32'(all_done()), 1);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] exp_grant;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int viol, abort_at, total;
        logic [N-1:0] g17;
        tbl[0] = '{4'b1111, 4'b0001}; tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b0001, 4'b0001}; tbl[3] = '{4'b1001, 4'b1000};
        tbl[4] = '{4'b0110, 4'b0010}; tbl[5] = '{4'b0010, 4'b0010};
        tbl[6] = '{4'b0101, 4'b0100}; tbl[7] = '{4'b0111, 4'b0001};
        for (int i = 0; i < N; i++) hold_off[i] = 1'b0;

        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_grant", grant_out, 0);
        check("rst_ready", req_ready_out, 0);
        check("rst_abort", abort_out, 0);
        check("rst_byte", tx_byte_out, 0);
        check("rst_trig", tx_trigger_out, 0);
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(negedge clk_in);

        // Single three-byte packet from requester 0.
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
        wait_grant(4'b0001, "t1_grant");
        wait_idle("t1_idle", 3000);
        check("t1_count", sent_byte.size(), 3);
        check("t1_trigs", trig_cnt, 3);
        for (int k = 0; k < 3 && k < sent_byte.size(); k++) begin
            check("t1_own", sent_own[k], 0);
            check("t1_byte", sent_byte[k], 8'h41 + k);
        end

        // Table: one-byte packets from a mask; losers withdraw once the winner is granted.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            int w;
            for (int i = 0; i < N; i++)
                if (tbl[k].mask[i]) push_byte(i, {4'(i + 1), 4'(k)}, 1);
            wait_any_grant("tbl_wait");
            check("tbl_grant", grant_out, tbl[k].exp_grant);
            w = idx_of(tbl[k].exp_grant);
            for (int i = 0; i < N; i++) if (i != w) withdraw(i);
            wait_idle("tbl_idle", 3000);
            check("tbl_byte", (sent_byte.size() > 0) ? sent_byte[$] : 8'h00, {4'(w + 1), 4'(k)});
        end

        // Fairness: all four held valid with two single-byte packets each.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_byte(i, 8'h10 * (i + 1) + r, 1);
        wait_idle("t2_idle", 5000);
        check("t2_count", sent_byte.size(), 8);
        for (int k = 0; k < 8 && k < sent_byte.size(); k++) begin
            check("t2_own", sent_own[k], k % N);
            check("t2_byte", sent_byte[k], 8'h10 * (k % N + 1) + k / N);
        end

        // Packet lock: owner 1 stalls between bytes while requester 2 waits.
        do_reset();
        push_byte(1, 8'hA1, 0);
        wait_grant(4'b0010, "t3_grant");
        push_byte(2, 8'hB2, 1);
        wait_trig(1, "t3_first");
        viol = 0;
        repeat (50) begin
            @(negedge clk_in);
            if (grant_out !== 4'b0010) viol++;
        end
        check("t3_lock", viol, 0);
        push_byte(1, 8'hA2, 1);
        wait_idle("t3_idle", 3000);
        check("t3_count", sent_byte.size(), 3);
        if (sent_byte.size() == 3) begin
            check("t3_order0", {sent_own[0][7:0], sent_byte[0]}, {8'd1, 8'hA1});
            check("t3_order1", {sent_own[1][7:0], sent_byte[1]}, {8'd1, 8'hA2});
            check("t3_order2", {sent_own[2][7:0], sent_byte[2]}, {8'd2, 8'hB2});
        end
        check("t3_abort", abort_cnt, 0);

        // Timeout: owner 0 goes silent mid-packet; requester 3 pending; 0 returns on the abort cycle.
        do_reset();
        push_byte(0, 8'h55, 0);
        wait_grant(4'b0001, "t4_grant");
        wait_trig(1, "t4_first");
        push_byte(3, 8'h77, 1);
        hold_off[0] = 1'b1;
        push_byte(0, 8'h56, 1);
        viol = 0;
        while (req_ready_out[0] !== 1'b1 && viol < 3000) begin @(negedge clk_in); viol++; end
        check("t4_reissue", req_ready_out[0], 1);
        abort_at = -1; g17 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            if (abort_out && abort_at < 0) abort_at = n;
            if (n == 15) hold_off[0] = 1'b0;
            if (n == 17) g17 = grant_out;
        end
        check("t4_abort_at", abort_at, 16);
        check("t4_abort_cnt", abort_cnt, 1);
        check("t4_next_grant", g17, 4'b1000);
        wait_idle("t4_idle", 3000);
        check("t4_count", sent_byte.size(), 3);
        if (sent_byte.size() == 3) begin
            check("t4_order1", {sent_own[1][7:0], sent_byte[1]}, {8'd3, 8'h77});
            check("t4_order2", {sent_own[2][7:0], sent_byte[2]}, {8'd0, 8'h56});
        end

        // Reset mid-frame with the transmitter left running.
        do_reset();
        push_byte(2, 8'h60, 1);
        wait_idle("t5_pre", 3000);
        push_byte(3, 8'h61, 1); push_byte(3, 8'h65, 1);
        wait_trig(2, "t5_trig");
        push_byte(1, 8'h63, 1);
        repeat (5) @(negedge clk_in);
        check("t5_busy", tx_busy_in, 1);
        @(posedge clk_in); #1 rst_n_in = 1'b0;
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(negedge clk_in);
        check("t5_grant0", grant_out, 0);
        check("t5_ready0", req_ready_out, 0);
        check("t5_byte0", tx_byte_out, 0);
        check("t5_trig0", {abort_out, tx_trigger_out}, 0);
        viol = 0;
        for (int n = 0; n < 3000 && tx_busy_in; n++) begin
            if (grant_out != '0) viol++;
            @(negedge clk_in);
        end
        check("t5_hold", viol, 0);
        wait_grant(4'b0010, "t5_first");
        wait_idle("t5_idle", 3000);
        check("t5_count", sent_byte.size(), 4);
        if (sent_byte.size() == 4) check("t5_last", {sent_own[3][7:0], sent_byte[3]}, {8'd3, 8'h65});

        // Randomized traffic against the scoreboard.
        do_reset();
        total = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_in);
            if (c < 600 && $urandom_range(0, 19) == 0) begin
                int r, len;
                r = $urandom_range(0, N - 1);
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) push_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
                total += len;
            end
        end
        wait_idle("rnd_idle", 20000);
        check("rnd_trigs", trig_cnt, total);
        check("rnd_abort", abort_cnt, 0);
        viol = 0;
        for (int i = 0; i < N; i++) viol += exp_dat[i].size();
        check("rnd_drained", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
